sum_uart_tx: RTL

Downstream stage for the 8-bit adder result of the TinyTapeout tile. It accepts one 8-bit sum per valid/ready handshake and serialises it as an 8N1 UART frame on one output pin, with optional even parity and a second stop bit. It drives one uo_out bit at top level, so a host can read results without sampling all eight parallel pins.

---
 rtl/sum_uart_tx.sv | 123 ++++++++++++
 1 files changed

// File: rtl/sum_uart_tx.sv
// UART transmitter for the adder sum: one byte per valid/ready handshake, sent as
// start, 8 data bits LSB first, optional even parity, then one or two stop bits.
module sum_uart_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int PARITY_EN    = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_i,
    input  logic       valid_i,
    output logic       ready_o,
    output logic       tx_o,
    output logic       busy_o,
    output logic       done_o
);

    localparam int CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);
    localparam logic LastStop = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t          state_q;
    logic [CntW-1:0] baudCnt_q;
    logic [2:0]      bitIdx_q;
    logic [7:0]      shift_q;
    logic            parity_q;
    logic            stopIdx_q;
    logic            tx_q;
    logic            done_q;
    logic            bitEnd;

    assign bitEnd  = (baudCnt_q == CntMax);
    assign ready_o = (state_q == IDLE);
    assign busy_o  = !ready_o;
    assign tx_o    = tx_q;
    assign done_o  = done_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            baudCnt_q <= '0;
            bitIdx_q  <= '0;
            shift_q   <= '0;
            parity_q  <= 1'b0;
            stopIdx_q <= 1'b0;
            tx_q      <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state_q != IDLE) begin
                baudCnt_q <= bitEnd ? '0 : baudCnt_q + CntW'(1);
            end
            case (state_q)
                IDLE: begin
                    if (valid_i) begin
                        shift_q   <= data_i;
                        parity_q  <= ^data_i;
                        baudCnt_q <= '0;
                        bitIdx_q  <= '0;
                        stopIdx_q <= 1'b0;
                        tx_q      <= 1'b0;
                        state_q   <= START;
                    end
                end
                START: begin
                    if (bitEnd) begin
                        tx_q    <= shift_q[0];
                        state_q <= DATA;
                    end
                end
                DATA: begin
                    // The next bit to drive is always shift_q[1] before the shift lands.
                    if (bitEnd) begin
                        shift_q <= shift_q >> 1;
                        if (bitIdx_q == 3'd7) begin
                            bitIdx_q <= '0;
                            if (PARITY_EN != 0) begin
                                tx_q    <= parity_q;
                                state_q <= PARITY;
                            end else begin
                                tx_q    <= 1'b1;
                                state_q <= STOP;
                            end
                        end else begin
                            bitIdx_q <= bitIdx_q + 3'd1;
                            tx_q     <= shift_q[1];
                        end
                    end
                end
                PARITY: begin
                    if (bitEnd) begin
                        tx_q    <= 1'b1;
                        state_q <= STOP;
                    end
                end
                STOP: begin
                    if (bitEnd) begin
                        if (stopIdx_q == LastStop) begin
                            stopIdx_q <= 1'b0;
                            done_q    <= 1'b1;
                            state_q   <= IDLE;
                        end else begin
                            stopIdx_q <= stopIdx_q + 1'b1;
                        end
                    end
                end
                default: begin
                    tx_q    <= 1'b1;
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule
